reg_exec_unit: RTL and testbench
================================

Name: reg_exec_unit

Overview:
- Multi-cycle execute/writeback sequencer that sits beside the 8x16 three-read-port register file.
- Accepts one instruction at a time over a valid/ready handshake and drives the file's read addresses A/B/C.
- Captures the returned operands, computes an ALU or multiply result, and writes it back through the file's single write port.
- Produces zero/carry status flags for the downstream control logic.

Parameters:
- DW, 16, data width; must match the register file.
- AW, 3, register address width (8 registers).
- MUL_CYCLES, 16, iterations of the shift-add multiplier; equals DW.

Ports:
- clk  in  1  system clock, rising edge
- nRESET  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  unit idle, can accept
- instr_op  in  3  opcode
- instr_rd  in  3  destination register
- instr_ra  in  3  source A
- instr_rb  in  3  source B
- instr_rc  in  3  source C (MAC addend)
- instr_imm  in  16  immediate for LDI
- read_addr_A  out  3  to register file
- read_addr_B  out  3  to register file
- read_addr_C  out  3  to register file
- read_data_A  in  16  from register file, combinational
- read_data_B  in  16  from register file, combinational
- read_data_C  in  16  from register file, combinational
- write_enable  out  1  register file write strobe
- write_addr  out  3  register file write address
- write_data  out  16  register file write data
- busy  out  1  equals ~instr_ready
- flag_zero  out  1  last written result == 0
- flag_carry  out  1  carry/borrow/overflow of last written result

Behaviour:
- Clock and reset: one clock, clk; reset nRESET is asynchronous, active-low. While low, all state clears:
  - FSM = IDLE.
  - instr_ready = 1.
  - write_enable = 0; write_addr, write_data, read_addr_A/B/C = 0.
  - flag_zero = 0, flag_carry = 0.
  - Internal operand and result registers = 0.
- Opcodes:
  - 000 LDI: rd = imm
  - 001 ADD: rd = ra + rb
  - 010 SUB: rd = ra - rb
  - 011 AND: rd = ra & rb
  - 100 OR: rd = ra | rb
  - 101 XOR: rd = ra ^ rb
  - 110 MUL: rd = low16(ra * rb)
  - 111 MAC: rd = low16(ra * rb + rc)
  - All arithmetic is unsigned.
- FSM states: IDLE, READ, EXEC, WB. All outputs are registered.
- IDLE:
  - instr_ready = 1.
  - On the edge with instr_valid & instr_ready: latch op, rd, imm; load read_addr_A/B/C from ra/rb/rc; go to READ.
  - instr_valid while not IDLE is ignored and held off by the source.
- READ (1 cycle): on the exiting edge, capture read_data_A/B/C into the operand registers; go to EXEC.
- EXEC:
  - Non-multiply ops: 1 cycle; result and flags computed, go to WB.
  - MUL/MAC: iterate MUL_CYCLES cycles, one multiplier bit per cycle LSB-first, 32-bit accumulator. For MAC, rc is added after the last iteration in the same cycle. Then go to WB.
- WB (1 cycle):
  - write_enable = 1, write_addr = rd, write_data = result.
  - flag_zero and flag_carry update on entry to WB.
  - Next edge: back to IDLE, write_enable drops to 0.
- Flags:
  - ADD: carry = bit 16 of the 17-bit sum.
  - SUB: carry = borrow (ra < rb).
  - LDI/AND/OR/XOR: carry = 0.
  - MUL/MAC: carry = 1 if the full product (plus rc) > 0xFFFF.
  - Flags hold between writebacks.
- Latency, with accept edge = E0:
  - Non-multiply ops: write_enable high in the cycle after E2, the file writes on E3. instr_ready returns on E3.
  - MUL/MAC: write_enable high in the cycle after E(MUL_CYCLES+1).
  - Peak throughput: one ALU op per 4 cycles.
- Hazards:
  - The next instruction cannot be accepted before E3+1, so its READ always sees the previous write. No forwarding is needed.
  - rd equal to ra/rb/rc is legal because operands are captured in READ.
  - Writing r0 is legal.
- Reset mid-operation: any state aborts immediately, no write is issued, flags are cleared.
- read_addr_A/B/C hold their last values after READ until the next accept.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: MUL/MAC behave as above, with the iterative multiplier compiled in.
- Undefined:
  - No multiplier logic. MUL/MAC pass through EXEC in 1 cycle.
  - WB still occupies 1 cycle but write_enable stays 0.
  - Flags are unchanged.
  - Latency equals the ALU ops.

Test Plan:
- Reset asserted mid-cycle, then released -> instr_ready=1, write_enable=0, read_addr_A/B/C=0, flag_zero=0, flag_carry=0. Checked both asynchronously during reset and after release.
- LDI r1=0x0005, LDI r2=0x0003, ADD r3=r1+r2 -> single-cycle write_enable with write_addr=3, write_data=0x0008, Z=0, C=0, asserted exactly 2 cycles after the accept edge.
- LDI r4=0xFFFF; ADD r5=r4+r1 -> 0x0004 C=1; SUB r6=r2-r2 -> 0x0000 Z=1 C=0; SUB r7=r2-r1 -> 0xFFFE C=1.
- MUL with r1=0x0100, r2=0x0100 -> 0x0000 Z=1 C=1, write 17 cycles after accept. MAC with ra=3, rb=5, rc=7 -> 0x0016. With EXEC_MUL_EN undefined -> no write_enable, flags unchanged.
- Reset pulsed during the 8th MUL iteration -> no write_enable, instr_ready=1 immediately, the register under test keeps its old value.
- instr_valid held high across back-to-back ADDs -> each accepted only in IDLE, one write per instruction, no instruction dropped or duplicated.

Source files
------------

// File: rtl/reg_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : reg_exec_unit
// Description : Multi-cycle execute/writeback sequencer for an 8x16 register
//               file with three combinational read ports and one write port.
//               Accepts one instruction at a time (valid/ready). It then reads
//               operands A/B/C and computes an ALU or multiply result. The
//               result is written back through the file's write port, and
//               zero/carry flags are updated with it.
//               FSM: IDLE -> READ -> EXEC (1 or MUL_CYCLES cycles) -> WB.
// Ports       : clk, nRESET (async, active-low)
//               instr_valid/instr_ready, instr_op/rd/ra/rb/rc/imm : instruction
//               read_addr_A/B/C, read_data_A/B/C                 : file reads
//               write_enable, write_addr, write_data             : file write
//               busy, flag_zero, flag_carry                      : status
// Macro       : EXEC_MUL_EN - when defined, compiles in the iterative
//               shift-add multiplier for MUL/MAC. When undefined, MUL/MAC
//               pass through in ALU time without writing or touching flags.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_exec_unit #(
   parameter int DW         = 16,
   parameter int AW         = 3,
   parameter int MUL_CYCLES = 16
) (
   input  logic          clk,
   input  logic          nRESET,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [2:0]    instr_op,
   input  logic [AW-1:0] instr_rd,
   input  logic [AW-1:0] instr_ra,
   input  logic [AW-1:0] instr_rb,
   input  logic [AW-1:0] instr_rc,
   input  logic [DW-1:0] instr_imm,
   output logic [AW-1:0] read_addr_A,
   output logic [AW-1:0] read_addr_B,
   output logic [AW-1:0] read_addr_C,
   input  logic [DW-1:0] read_data_A,
   input  logic [DW-1:0] read_data_B,
   input  logic [DW-1:0] read_data_C,
   output logic          write_enable,
   output logic [AW-1:0] write_addr,
   output logic [DW-1:0] write_data,
   output logic          busy,
   output logic          flag_zero,
   output logic          flag_carry
);

   localparam logic [2:0] c_OP_LDI = 3'b000;
   localparam logic [2:0] c_OP_ADD = 3'b001;
   localparam logic [2:0] c_OP_SUB = 3'b010;
   localparam logic [2:0] c_OP_AND = 3'b011;
   localparam logic [2:0] c_OP_OR  = 3'b100;
   localparam logic [2:0] c_OP_XOR = 3'b101;
   localparam logic [2:0] c_OP_MAC = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t r_state, w_state_next;

   logic          r_ready, r_busy, r_we, r_fz, r_fc;
   logic [AW-1:0] r_raddr_a, r_raddr_b, r_raddr_c, r_waddr, r_rd;
   logic [DW-1:0] r_wdata, r_imm, r_opa, r_opb, r_opc;
   logic [2:0]    r_op;

   logic          w_accept, w_is_mul, w_exec_fin, w_wr_ok, w_cy;
   logic [DW:0]   w_alu;
   logic [DW-1:0] w_res;

   // MUL (110) and MAC (111) share the top two opcode bits
   assign w_is_mul = (r_op[2:1] == 2'b11);

   // ALU result with the carry/borrow in the extra top bit
   always_comb begin
      w_alu = '0;
      case (r_op)
         c_OP_LDI: w_alu = {1'b0, r_imm};
         c_OP_ADD: w_alu = {1'b0, r_opa} + {1'b0, r_opb};
         c_OP_SUB: w_alu = {1'b0, r_opa} - {1'b0, r_opb};  // top bit = borrow
         c_OP_AND: w_alu = {1'b0, r_opa & r_opb};
         c_OP_OR:  w_alu = {1'b0, r_opa | r_opb};
         c_OP_XOR: w_alu = {1'b0, r_opa ^ r_opb};
         default:  w_alu = '0;
      endcase
   end

`ifdef EXEC_MUL_EN
   localparam int CW = $clog2(MUL_CYCLES + 1);

   logic [2*DW-1:0] r_mcand, r_acc, w_acc_step, w_mul_res;
   logic [DW-1:0]   r_mplier;
   logic [CW-1:0]   r_cnt;
   logic            w_mul_last;

   // One multiplier bit per cycle, LSB first; the MAC addend joins the
   // final partial sum so the last iteration and the add share one cycle.
   always_comb begin
      w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
      w_mul_res  = w_acc_step + ((r_op == c_OP_MAC) ? {{DW{1'b0}}, r_opc} : '0);
      w_mul_last = (r_cnt == CW'(MUL_CYCLES - 1));
   end

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (r_state == S_READ) begin
         r_mcand  <= {{DW{1'b0}}, read_data_A};
         r_mplier <= read_data_B;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if ((r_state == S_EXEC) && w_is_mul) begin
         r_acc    <= w_acc_step;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
      end
   end

   assign w_exec_fin = !w_is_mul || w_mul_last;
   assign w_wr_ok    = 1'b1;
   assign w_res      = w_is_mul ? w_mul_res[DW-1:0] : w_alu[DW-1:0];
   assign w_cy       = w_is_mul ? (|w_mul_res[2*DW-1:DW]) : w_alu[DW];
`else
   // Without the multiplier, MUL/MAC drain in ALU time and never write
   logic w_unused_nomul;
   assign w_unused_nomul = ^{r_opc, 1'(MUL_CYCLES)};

   assign w_exec_fin = 1'b1;
   assign w_wr_ok    = !w_is_mul;
   assign w_res      = w_alu[DW-1:0];
   assign w_cy       = w_alu[DW];
`endif

   // FSM: state register
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // FSM: next state and control strobes
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: if (instr_valid) begin
            w_accept     = 1'b1;
            w_state_next = S_READ;
         end
         S_READ: w_state_next = S_EXEC;
         S_EXEC: if (w_exec_fin) w_state_next = S_WB;
         S_WB:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_we      <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_fz      <= 1'b0;
         r_fc      <= 1'b0;
         r_raddr_a <= '0;
         r_raddr_b <= '0;
         r_raddr_c <= '0;
         r_op      <= '0;
         r_rd      <= '0;
         r_imm     <= '0;
         r_opa     <= '0;
         r_opb     <= '0;
         r_opc     <= '0;
      end else begin
         r_ready <= (w_state_next == S_IDLE);
         r_busy  <= (w_state_next != S_IDLE);
         r_we    <= 1'b0;
         if (w_accept) begin
            r_op      <= instr_op;
            r_rd      <= instr_rd;
            r_imm     <= instr_imm;
            r_raddr_a <= instr_ra;
            r_raddr_b <= instr_rb;
            r_raddr_c <= instr_rc;
         end
         // Operands captured here, so rd may alias any source register
         if (r_state == S_READ) begin
            r_opa <= read_data_A;
            r_opb <= read_data_B;
            r_opc <= read_data_C;
         end
         if ((r_state == S_EXEC) && w_exec_fin && w_wr_ok) begin
            r_we    <= 1'b1;
            r_waddr <= r_rd;
            r_wdata <= w_res;
            r_fz    <= (w_res == '0);
            r_fc    <= w_cy;
         end
      end
   end

   assign instr_ready  = r_ready;
   assign busy         = r_busy;
   assign write_enable = r_we;
   assign write_addr   = r_waddr;
   assign write_data   = r_wdata;
   assign flag_zero    = r_fz;
   assign flag_carry   = r_fc;
   assign read_addr_A  = r_raddr_a;
   assign read_addr_B  = r_raddr_b;
   assign read_addr_C  = r_raddr_c;

endmodule
`default_nettype wire

// File: tb/tb_reg_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_exec_unit
// Description : Directed self-checking bench for reg_exec_unit with an 8x16
//               register file model (combinational reads, clocked write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_exec_unit;

   logic        clk = 1'b0;
   logic        nRESET;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  instr_op, instr_rd, instr_ra, instr_rb, instr_rc;
   logic [15:0] instr_imm;
   logic [2:0]  read_addr_A, read_addr_B, read_addr_C;
   logic [15:0] read_data_A, read_data_B, read_data_C;
   logic        write_enable;
   logic [2:0]  write_addr;
   logic [15:0] write_data;
   logic        busy, flag_zero, flag_carry;

   always #5 clk = ~clk;

   reg_exec_unit dut (
      .clk(clk), .nRESET(nRESET),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra),
      .instr_rb(instr_rb), .instr_rc(instr_rc), .instr_imm(instr_imm),
      .read_addr_A(read_addr_A), .read_addr_B(read_addr_B), .read_addr_C(read_addr_C),
      .read_data_A(read_data_A), .read_data_B(read_data_B), .read_data_C(read_data_C),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .busy(busy), .flag_zero(flag_zero), .flag_carry(flag_carry)
   );

   // Register file model
   logic [15:0] rf [0:7];
   int          wr_cnt  = 0;
   int          acc_cnt = 0;

   assign read_data_A = rf[read_addr_A];
   assign read_data_B = rf[read_addr_B];
   assign read_data_C = rf[read_addr_C];

   always @(posedge clk) begin
      if (write_enable) begin
         rf[write_addr] <= write_data;
         wr_cnt         <= wr_cnt + 1;
      end
   end

   // Count handshakes that will complete on the coming rising edge
   always @(negedge clk) begin
      #2;
      if (instr_valid && instr_ready && nRESET) acc_cnt = acc_cnt + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one instruction and follow it until instr_ready returns
   task automatic run_op(input logic [2:0] op, rd, ra, rb, rc, input logic [15:0] imm,
                         output int we_n, output int we_lat, output int rdy_lat,
                         output logic [2:0] wa, output logic [15:0] wd,
                         output logic fz, output logic fc);
      int k;
      we_n = 0; we_lat = -1; rdy_lat = -1; wa = '0; wd = '0; fz = 1'b0; fc = 1'b0;
      k = 0;
      @(negedge clk);
      while (!instr_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) chk("ready_wait_timeout", 32'(k), 32'd0);
      instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_rc = rc;
      instr_imm = imm; instr_valid = 1'b1;
      @(posedge clk);          // accept edge E0
      #1 instr_valid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (write_enable) begin
            we_n++;
            if (we_lat < 0) begin
               we_lat = c; wa = write_addr; wd = write_data;
               fz = flag_zero; fc = flag_carry;
            end
         end
         if (instr_ready) begin
            rdy_lat = c;
            break;
         end
      end
      if (rdy_lat < 0) chk("op_done_timeout", 32'hFFFF_FFFF, 32'd0);
   endtask

   // Issue an op expected to write once with ALU latency
   task automatic do_alu(input string tag, input logic [2:0] op, rd, ra, rb, rc,
                         input logic [15:0] imm, input logic [15:0] ed,
                         input logic ez, input logic ec);
      int n, wl, rl;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic        fz, fc;
      run_op(op, rd, ra, rb, rc, imm, n, wl, rl, wa, wd, fz, fc);
      chk({tag, ".nwr"},  32'(n),  32'd1);
      chk({tag, ".wlat"}, 32'(wl), 32'd2);
      chk({tag, ".rlat"}, 32'(rl), 32'd3);
      chk({tag, ".addr"}, 32'(wa), 32'(rd));
      chk({tag, ".data"}, 32'(wd), 32'(ed));
      chk({tag, ".z"},    32'(fz), 32'(ez));
      chk({tag, ".c"},    32'(fc), 32'(ec));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, wl, rl, a0, w0;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic        fz, fc;

      for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
      nRESET = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
      instr_ra = '0; instr_rb = '0; instr_rc = '0; instr_imm = '0;

      // Reset asserted mid-cycle, checked while asserted and after release
      #23 nRESET = 1'b0;
      #1;
      chk("rst_async.ready", 32'(instr_ready), 32'd1);
      chk("rst_async.we",    32'(write_enable), 32'd0);
      chk("rst_async.raddr", 32'({read_addr_A, read_addr_B, read_addr_C}), 32'd0);
      chk("rst_async.flags", 32'({flag_zero, flag_carry}), 32'd0);
      @(negedge clk) nRESET = 1'b1;
      @(posedge clk); #1;
      chk("rst_rel.ready", 32'(instr_ready), 32'd1);
      chk("rst_rel.busy",  32'(busy), 32'd0);
      chk("rst_rel.we",    32'(write_enable), 32'd0);
      chk("rst_rel.raddr", 32'({read_addr_A, read_addr_B, read_addr_C}), 32'd0);
      chk("rst_rel.flags", 32'({flag_zero, flag_carry}), 32'd0);

      // Basic ALU sequence
      do_alu("ldi_r1", 3'b000, 3'd1, 3'd0, 3'd0, 3'd0, 16'h0005, 16'h0005, 1'b0, 1'b0);
      do_alu("ldi_r2", 3'b000, 3'd2, 3'd0, 3'd0, 3'd0, 16'h0003, 16'h0003, 1'b0, 1'b0);
      do_alu("add_r3", 3'b001, 3'd3, 3'd1, 3'd2, 3'd0, 16'h0000, 16'h0008, 1'b0, 1'b0);
      do_alu("ldi_r4", 3'b000, 3'd4, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      do_alu("add_cy", 3'b001, 3'd5, 3'd4, 3'd1, 3'd0, 16'h0000, 16'h0004, 1'b0, 1'b1);
      do_alu("sub_z",  3'b010, 3'd6, 3'd2, 3'd2, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      do_alu("sub_bw", 3'b010, 3'd7, 3'd2, 3'd1, 3'd6, 16'h0000, 16'hFFFE, 1'b0, 1'b1);
      chk("raddr_hold", 32'({read_addr_A, read_addr_B, read_addr_C}), 32'({3'd2, 3'd1, 3'd6}));
      do_alu("and",    3'b011, 3'd3, 3'd4, 3'd1, 3'd0, 16'h0000, 16'h0005, 1'b0, 1'b0);
      do_alu("or",     3'b100, 3'd3, 3'd1, 3'd2, 3'd0, 16'h0000, 16'h0007, 1'b0, 1'b0);
      do_alu("xor",    3'b101, 3'd3, 3'd1, 3'd2, 3'd0, 16'h0000, 16'h0006, 1'b0, 1'b0);
      do_alu("alias",  3'b001, 3'd2, 3'd2, 3'd2, 3'd0, 16'h0000, 16'h0006, 1'b0, 1'b0);
      chk("alias.rf", 32'(rf[2]), 32'h0006);
      do_alu("ldi_r0", 3'b000, 3'd0, 3'd0, 3'd0, 3'd0, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0);
      chk("ldi_r0.rf", 32'(rf[0]), 32'hA5A5);

      // MUL: 0x0100 * 0x0100, preceded by an op that leaves C=1
      do_alu("ldi_m1", 3'b000, 3'd1, 3'd0, 3'd0, 3'd0, 16'h0100, 16'h0100, 1'b0, 1'b0);
      do_alu("ldi_m2", 3'b000, 3'd2, 3'd0, 3'd0, 3'd0, 16'h0100, 16'h0100, 1'b0, 1'b0);
      do_alu("add_ff", 3'b001, 3'd5, 3'd4, 3'd1, 3'd0, 16'h0000, 16'h00FF, 1'b0, 1'b1);
      run_op(3'b110, 3'd3, 3'd1, 3'd2, 3'd0, 16'h0000, n, wl, rl, wa, wd, fz, fc);
`ifdef EXEC_MUL_EN
      chk("mul.nwr",  32'(n),  32'd1);
      chk("mul.wlat", 32'(wl), 32'd17);
      chk("mul.rlat", 32'(rl), 32'd18);
      chk("mul.addr", 32'(wa), 32'd3);
      chk("mul.data", 32'(wd), 32'h0000);
      chk("mul.z",    32'(fz), 32'd1);
      chk("mul.c",    32'(fc), 32'd1);
`else
      chk("mul.nwr",   32'(n),  32'd0);
      chk("mul.rlat",  32'(rl), 32'd3);
      chk("mul.flags", 32'({flag_zero, flag_carry}), 32'({1'b0, 1'b1}));
      chk("mul.rf",    32'(rf[3]), 32'h0006);
`endif

      // MAC: 3 * 5 + 7
      do_alu("ldi_a", 3'b000, 3'd1, 3'd0, 3'd0, 3'd0, 16'h0003, 16'h0003, 1'b0, 1'b0);
      do_alu("ldi_b", 3'b000, 3'd2, 3'd0, 3'd0, 3'd0, 16'h0005, 16'h0005, 1'b0, 1'b0);
      do_alu("ldi_c", 3'b000, 3'd4, 3'd0, 3'd0, 3'd0, 16'h0007, 16'h0007, 1'b0, 1'b0);
      run_op(3'b111, 3'd5, 3'd1, 3'd2, 3'd4, 16'h0000, n, wl, rl, wa, wd, fz, fc);
`ifdef EXEC_MUL_EN
      chk("mac.nwr",  32'(n),  32'd1);
      chk("mac.wlat", 32'(wl), 32'd17);
      chk("mac.data", 32'(wd), 32'h0016);
      chk("mac.flags", 32'({fz, fc}), 32'd0);
`else
      chk("mac.nwr",  32'(n),  32'd0);
      chk("mac.rlat", 32'(rl), 32'd3);
      chk("mac.rf",   32'(rf[5]), 32'h00FF);
`endif

      // Reset during the 8th MUL iteration (ALU op in EXEC without the multiplier)
      w0 = wr_cnt;
      @(negedge clk);
`ifdef EXEC_MUL_EN
      instr_op = 3'b110;
`else
      instr_op = 3'b001;
`endif
      instr_rd = 3'd6; instr_ra = 3'd1; instr_rb = 3'd2; instr_rc = 3'd0;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
`ifdef EXEC_MUL_EN
      repeat (8) @(posedge clk);
`else
      repeat (1) @(posedge clk);
`endif
      #3 nRESET = 1'b0;
      #1;
      chk("midrst.ready", 32'(instr_ready), 32'd1);
      chk("midrst.we",    32'(write_enable), 32'd0);
      chk("midrst.flags", 32'({flag_zero, flag_carry}), 32'd0);
      @(negedge clk) nRESET = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      chk("midrst.nwr", 32'(wr_cnt - w0), 32'd0);
      chk("midrst.rf",  32'(rf[6]), 32'h0000);

      // Back-to-back ADDs with instr_valid held high
      do_alu("ldi_r7", 3'b000, 3'd7, 3'd0, 3'd0, 3'd0, 16'h0010, 16'h0010, 1'b0, 1'b0);
      a0 = acc_cnt;
      w0 = wr_cnt;
      @(negedge clk);
      instr_op = 3'b001; instr_rd = 3'd7; instr_ra = 3'd7; instr_rb = 3'd1; instr_rc = 3'd0;
      instr_valid = 1'b1;
      repeat (12) @(posedge clk);
      #1 instr_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("b2b.accepts", 32'(acc_cnt - a0), 32'd3);
      chk("b2b.writes",  32'(wr_cnt - w0),  32'd3);
      chk("b2b.rf",      32'(rf[7]), 32'h0019);
      chk("b2b.ready",   32'(instr_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
